// File: rtl/elliptic_curve_structs.sv
`default_nettype none
// ============================================================================
// Package     : elliptic_curve_structs
// Description : Shared widths and types for the modular-arithmetic blocks.
//               P_WIDTH is the prime-field operand width; mult_state_t is the
//               state type used by enable/done handshake responders.
// Revision    : 1.0 - initial release
// ============================================================================
package elliptic_curve_structs;

  localparam int P_WIDTH = 256;

  // Handshake responder state: waiting, computing, result held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Number of DIGIT-sized chunks needed to cover WIDTH bits.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_partial_product.sv
`default_nettype none
// ============================================================================
// Module      : digit_partial_product
// Description : Combinational unsigned WIDTH x DIGIT_BITS multiply.
// Ports       : a     in  WIDTH             multiplicand
//               digit in  DIGIT_BITS        one digit of the multiplier
//               pp    out WIDTH+DIGIT_BITS  a * digit (exact, never truncated)
// Revision    : 1.0 - initial release
// ============================================================================
module digit_partial_product #(
  parameter int WIDTH      = 8,
  parameter int DIGIT_BITS = 4
) (
  input  logic [WIDTH-1:0]            a,
  input  logic [DIGIT_BITS-1:0]       digit,
  output logic [WIDTH+DIGIT_BITS-1:0] pp
);

  localparam int c_PP_W = WIDTH + DIGIT_BITS;

  // Both operands widened first so the multiply is carried out at full width.
  assign pp = c_PP_W'(a) * c_PP_W'(digit);

endmodule
`default_nettype wire

// File: rtl/digit_serial_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_multiplier
// Description : Enable/done handshake responder computing ab = a*b (unsigned),
//               consuming DIGIT_BITS bits of b per clock. NDIG = ceil(WIDTH /
//               DIGIT_BITS) BUSY cycles per product.
// Ports       : clk    in  1        rising-edge clock
//               reset  in  1        synchronous, active-low reset
//               enable in  1        start/hold request (level)
//               a      in  WIDTH    multiplicand
//               b      in  WIDTH    multiplier
//               ab     out 2*WIDTH  product, valid while done==1 (registered)
//               done   out 1        result valid, sticky while enable held
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_multiplier
  import elliptic_curve_structs::*;
#(
  parameter int WIDTH      = P_WIDTH,
  parameter int DIGIT_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] ab,
  output logic               done
);

  localparam int c_NDIG  = ceil_div(WIDTH, DIGIT_BITS);
  localparam int c_BEXT  = c_NDIG * DIGIT_BITS;
  localparam int c_CNT_W = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
  localparam int c_PP_W  = WIDTH + DIGIT_BITS;
  localparam int c_ACC_W = 2 * WIDTH;

  mult_state_t          r_state;
  mult_state_t          w_next_state;
  logic [WIDTH-1:0]     r_a;
  logic [c_BEXT-1:0]    r_b;
  logic [c_ACC_W-1:0]   r_acc;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_ACC_W-1:0]   r_ab;
  logic                 r_done;

  logic [c_PP_W-1:0]    w_pp;
  logic [c_ACC_W-1:0]   w_pp_ext;
  logic [c_ACC_W-1:0]   w_pp_shift;
  logic [c_ACC_W-1:0]   w_acc_next;
  logic                 w_last;

  // The low digit of r_b is always the one being consumed; r_b shifts right
  // each BUSY cycle. Its zero-extended top bits make the final digit harmless
  // when DIGIT_BITS does not divide WIDTH.
  digit_partial_product #(
    .WIDTH      (WIDTH),
    .DIGIT_BITS (DIGIT_BITS)
  ) u_pp (
    .a     (r_a),
    .digit (r_b[DIGIT_BITS-1:0]),
    .pp    (w_pp)
  );

  // Weight the partial product by 2^(count*DIGIT_BITS). Bits shifted past the
  // accumulator top are provably zero since the full product fits in 2*WIDTH.
  assign w_pp_ext   = c_ACC_W'(w_pp);
  assign w_pp_shift = w_pp_ext << (int'(r_count) * DIGIT_BITS);
  assign w_acc_next = r_acc + w_pp_shift;
  assign w_last     = (r_count == c_CNT_W'(c_NDIG - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; dropping enable always returns to IDLE.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (enable) w_next_state = BUSY;
      end
      BUSY: begin
        if (!enable)     w_next_state = IDLE;
        else if (w_last) w_next_state = DONE;
      end
      DONE: begin
        if (!enable) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, digit accumulation, result/done registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_ab    <= '0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (enable) begin
            r_a     <= a;
            r_b     <= c_BEXT'(b);
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        BUSY: begin
          if (!enable) begin
            // Abort: previous ab is left untouched.
            r_done <= 1'b0;
          end else begin
            r_acc   <= w_acc_next;
            r_b     <= r_b >> DIGIT_BITS;
            r_count <= r_count + c_CNT_W'(1);
            if (w_last) begin
              r_ab   <= w_acc_next;
              r_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!enable) r_done <= 1'b0;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign ab   = r_ab;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_serial_multiplier
// Description : Self-checking bench for digit_serial_multiplier. Three
//               instances (8/4, 8/3, 256/4) share one handshake so every
//               operation exercises all three digit geometries at once.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_multiplier;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [255:0] a;
  logic [255:0] b;
  logic [15:0]  ab_d4;
  logic [15:0]  ab_d3;
  logic [511:0] ab_w;
  logic         done_d4;
  logic         done_d3;
  logic         done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_serial_multiplier #(.WIDTH(8), .DIGIT_BITS(4)) u_d4 (
    .clk(clk), .reset(rst_n), .enable(en), .a(a[7:0]), .b(b[7:0]),
    .ab(ab_d4), .done(done_d4)
  );

  digit_serial_multiplier #(.WIDTH(8), .DIGIT_BITS(3)) u_d3 (
    .clk(clk), .reset(rst_n), .enable(en), .a(a[7:0]), .b(b[7:0]),
    .ab(ab_d3), .done(done_d3)
  );

  digit_serial_multiplier #(.WIDTH(256), .DIGIT_BITS(4)) u_w (
    .clk(clk), .reset(rst_n), .enable(en), .a(a), .b(b),
    .ab(ab_w), .done(done_w)
  );

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: plain full-width arithmetic.
  function automatic logic [15:0] model8(input logic [255:0] x, input logic [255:0] y);
    return 16'(x[7:0]) * 16'(y[7:0]);
  endfunction

  function automatic logic [511:0] model256(input logic [255:0] x, input logic [255:0] y);
    return 512'(x) * 512'(y);
  endfunction

  // Full handshake: raise enable, measure latency of each instance, optionally
  // scramble inputs after the latching edge, hold for extra cycles, drop enable.
  task automatic do_op(input logic [255:0] va, input logic [255:0] vb,
                       input bit scramble, input int hold);
    int lat_d4, lat_d3, lat_w;
    logic [15:0]  e8;
    logic [511:0] ew;
    e8 = model8(va, vb);
    ew = model256(va, vb);
    lat_d4 = -1; lat_d3 = -1; lat_w = -1;
    a = va; b = vb; en = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (scramble && k == 1) begin a = rand256(); b = rand256(); end
      if (done_d4 && lat_d4 < 0) lat_d4 = k - 1;
      if (done_d3 && lat_d3 < 0) lat_d3 = k - 1;
      if (done_w  && lat_w  < 0) lat_w  = k - 1;
      if (done_w) break;
    end
    check("latency_d4", 512'(lat_d4), 512'(2));
    check("latency_d3", 512'(lat_d3), 512'(3));
    check("latency_w",  512'(lat_w),  512'(64));
    check("ab_d4", 512'(ab_d4), 512'(e8));
    check("ab_d3", 512'(ab_d3), 512'(e8));
    check("ab_w",  ab_w, ew);
    check("sticky_d4", 512'(done_d4), 512'(1));
    for (int h = 0; h < hold; h++) begin
      a = rand256(); b = rand256();
      tick();
      check("hold_done_d4", 512'(done_d4), 512'(1));
      check("hold_ab_d4",   512'(ab_d4),   512'(e8));
      check("hold_ab_w",    ab_w,          ew);
    end
    en = 1'b0;
    tick();
    check("drop_done_d4", 512'(done_d4), 512'(0));
    check("drop_done_d3", 512'(done_d3), 512'(0));
    check("drop_done_w",  512'(done_w),  512'(0));
    check("drop_ab_d3",   512'(ab_d3),   512'(e8));
  endtask

  vec_t vecs[7];

  initial begin
    logic [15:0] prev8;
    bit          seen;

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'hA5, 8'h3C, 16'h26AC};
    vecs[2] = '{8'h00, 8'h3C, 16'h0000};
    vecs[3] = '{8'hA5, 8'h00, 16'h0000};
    vecs[4] = '{8'h02, 8'h03, 16'h0006};
    vecs[5] = '{8'h80, 8'h80, 16'h4000};
    vecs[6] = '{8'h01, 8'hFF, 16'h00FF};

    rst_n = 1'b0; en = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("rst_done_d4", 512'(done_d4), 512'(0));
    check("rst_done_w",  512'(done_w),  512'(0));
    check("rst_ab_d4",   512'(ab_d4),   512'(0));
    check("rst_ab_w",    ab_w,          512'(0));
    rst_n = 1'b1;
    tick();

    // Table: first entry also holds enable for 10 cycles while inputs change.
    for (int i = 0; i < 7; i++) begin
      do_op(256'(vecs[i].va), 256'(vecs[i].vb), (i % 2) == 1, (i == 0) ? 10 : 0);
      check("table_ab_d4", 512'(ab_d4), 512'(vecs[i].exp));
      check("table_ab_d3", 512'(ab_d3), 512'(vecs[i].exp));
    end

    // Reset in the middle of an operation.
    a = 256'h1234; b = 256'hFEDC; en = 1'b1;
    tick();
    rst_n = 1'b0; en = 1'b0;
    tick();
    check("midrst_done_d4", 512'(done_d4), 512'(0));
    check("midrst_done_w",  512'(done_w),  512'(0));
    check("midrst_ab_d4",   512'(ab_d4),   512'(0));
    check("midrst_ab_d3",   512'(ab_d3),   512'(0));
    check("midrst_ab_w",    ab_w,          512'(0));
    rst_n = 1'b1;
    tick();
    check("postrst_done_d3", 512'(done_d3), 512'(0));
    do_op(256'h37, 256'h59, 1'b0, 0);
    prev8 = model8(256'h37, 256'h59);

    // Abort: enable dropped while BUSY; done must never rise.
    a = 256'hC3; b = 256'h7E; en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done_d4 || done_d3 || done_w) seen = 1'b1;
    end
    check("abort_done_seen", 512'(seen), 512'(0));
    check("abort_ab_d4", 512'(ab_d4), 512'(prev8));
    check("abort_ab_d3", 512'(ab_d3), 512'(prev8));
    do_op(256'hC3, 256'h7E, 1'b0, 0);

    // Wide boundary and random operands.
    do_op({256{1'b1}}, {256{1'b1}}, 1'b0, 0);
    for (int r = 0; r < 1000; r++) begin
      do_op(rand256(), rand256(), ($urandom % 2) == 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
